mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Time-slot arbiter that shares the external memory bus between the N6502 core and a second master, the DMA port used by the USB/debug loader. Each bus access is a slot of WAIT+1 cycles. The block stalls the core through its hold input while the core waits on slow memory or while the DMA master owns the bus. It sits between the core and the board pins: address, data-in, data-out and we.

Parameters:
ADDR_W, 16, width of the CPU, DMA and memory address.
WAIT, 1, wait cycles per access (range 0..15); a slot lasts WAIT+1 cycles.
CPU_SLOTS, 1, consecutive CPU slots that must complete before a pending DMA request is granted (range 1..15).

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
cpu_address  in  ADDR_W  core address.
cpu_out  in  8  core write data.
cpu_we  in  1  core write enable.
cpu_in  out  8  read data to the core.
cpu_hold  out  1  core run enable (1 = core advances this edge).
dma_req  in  1  DMA access request (level).
dma_address  in  ADDR_W  DMA address.
dma_wdata  in  8  DMA write data.
dma_we  in  1  DMA write (1) or read (0).
dma_ack  out  1  DMA slot completing this cycle.
dma_rdata  out  8  DMA read data, valid while dma_ack = 1.
mem_address  out  ADDR_W  memory address.
mem_wdata  out  8  memory write data.
mem_we  out  1  memory write strobe.
mem_rdata  in  8  memory read data (combinational memory).

Behaviour:
- State:
  - owner: CPU or DMA.
  - cnt: 0..WAIT, position within the current slot.
  - run: completed CPU slots since the last DMA slot, saturating at CPU_SLOTS.
  - dlat: latched DMA address, data and we.
- Reset, while asserted and on release:
  - owner = CPU, cnt = 0, run = 0, dlat = 0.
  - mem_we = 0 and dma_ack = 0, forced regardless of state.
  - cpu_hold = 1 only if WAIT = 0; otherwise cpu_hold = 0.
- Slot end: the cycle in which cnt == WAIT. On every other cycle, cnt increments.
- Slot-end edge decision:
  - First update run: set to 0 if owner = DMA; otherwise increment run, saturating at CPU_SLOTS.
  - If dma_req = 1 and the updated run >= CPU_SLOTS, the next owner is DMA; capture dma_address, dma_wdata and dma_we into dlat on that same edge.
  - Otherwise the next owner is CPU.
  - cnt returns to 0.
- Bus mux, combinational:
  - owner = CPU: mem_address = cpu_address, mem_wdata = cpu_out.
  - owner = DMA: mem_address, mem_wdata and the write flag all come from dlat.
- mem_we is high only during the slot-end cycle, and only when the owner's write flag is set. It is never high in wait cycles.
- owner = CPU:
  - cpu_hold = 1 only in the slot-end cycle.
  - cpu_in = mem_rdata (combinational).
- owner = DMA:
  - cpu_hold = 0 for the whole slot.
  - cpu_in holds the last value presented during a CPU slot-end cycle, kept in a register.
- dma_ack = 1 only in the DMA slot-end cycle; dma_rdata = mem_rdata in that cycle.
- The DMA master samples ack and data on that edge. It may keep dma_req high for the next transfer; that transfer is granted after CPU_SLOTS further CPU slots.
- A granted DMA slot always completes from dlat, even if dma_req drops mid-slot. A req dropped before grant is never served.
- DMA is never granted mid-slot. Back-to-back DMA slots are impossible because CPU_SLOTS >= 1.
- Reset mid-slot: the slot is aborted, with no write and no ack; the CPU owns the next slot.
- Throughput: with dma_req held continuously and CPU_SLOTS = 1, ownership alternates CPU, DMA, CPU, ...

Test Plan:
- Reset, WAIT=1, no DMA: cpu_hold toggles 0,1,0,1 from the first post-reset cycle. cpu_we=1, cpu_address=16'h0200, cpu_out=8'h5A → exactly one mem_we pulse per slot, on the cycle cpu_hold=1.
- WAIT=0, dma_req=0 → cpu_hold stays 1 every cycle; mem_address tracks cpu_address with zero latency.
- dma_req=1, dma_we=0, dma_address=16'h1234, memory returns 8'hA7 (WAIT=1, CPU_SLOTS=1) → after the current CPU slot, mem_address=1234 for 2 cycles, cpu_hold=0 for both, dma_ack=1 with dma_rdata=A7 on the second, mem_we=0 throughout.
- dma_req held high with writes, CPU_SLOTS=3, WAIT=0 → pattern of 3 CPU cycles then 1 DMA cycle repeats. Exactly one mem_we per DMA slot carries dma_wdata.
- dma_req pulsed for 1 cycle mid-CPU-slot (cnt=0, WAIT=2) → no grant, no ack. dma_req dropped after grant → slot still completes, ack pulses, the write lands at the latched address.
- reset asserted during the first wait cycle of a DMA write slot → no mem_we, no ack. After release, owner=CPU with cnt=0 and cpu_hold follows the reset-release rule.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the core, the DMA loader port and the memory pins.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_address;
  logic [7:0]        cpu_out;
  logic              cpu_we;
  logic [7:0]        cpu_in;
  logic              cpu_hold;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_address;
  logic [7:0]        dma_wdata;
  logic              dma_we;
  logic              dma_ack;
  logic [7:0]        dma_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_address, cpu_out, cpu_we,
    input  dma_req, dma_address, dma_wdata, dma_we,
    input  mem_rdata,
    output cpu_in, cpu_hold,
    output dma_ack, dma_rdata,
    output mem_address, mem_wdata, mem_we
  );

  modport master (
    output cpu_address, cpu_out, cpu_we,
    output dma_req, dma_address, dma_wdata, dma_we,
    output mem_rdata,
    input  cpu_in, cpu_hold,
    input  dma_ack, dma_rdata,
    input  mem_address, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Time-slot arbiter sharing the memory bus between the core and the DMA loader port.
// Each access is a slot of WAIT+1 cycles; DMA is granted only at slot ends after CPU_SLOTS CPU slots.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WAIT      = 1,
  parameter int unsigned CPU_SLOTS = 1
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned CW = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  owner_t            owner;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     run;
  logic [ADDR_W-1:0] dlat_addr;
  logic [7:0]        dlat_wdata;
  logic              dlat_we;
  logic [7:0]        cpu_in_q;

  logic              slot_end;
  logic              is_dma;
  logic              wr_flag;
  logic              grant;
  logic [CW-1:0]     run_upd;

  assign slot_end = (cnt == CW'(WAIT));
  assign is_dma   = (owner == OWN_DMA);

  // CPU-slot run length as it will stand after the current slot completes
  always_comb begin
    run_upd = '0;
    if (!is_dma) begin
      run_upd = (run >= CW'(CPU_SLOTS)) ? run : run + CW'(1);
    end
  end

  assign grant = bus.dma_req && (run_upd >= CW'(CPU_SLOTS));

  // Slot sequencing, ownership decision and DMA request latch
  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= OWN_CPU;
      cnt        <= '0;
      run        <= '0;
      dlat_addr  <= '0;
      dlat_wdata <= '0;
      dlat_we    <= 1'b0;
      cpu_in_q   <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      run <= run_upd;
      if (!is_dma) begin
        cpu_in_q <= bus.mem_rdata;
      end
      if (grant) begin
        owner      <= OWN_DMA;
        dlat_addr  <= bus.dma_address;
        dlat_wdata <= bus.dma_wdata;
        dlat_we    <= bus.dma_we;
      end else begin
        owner <= OWN_CPU;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Memory-side mux; strobes are squashed while reset is asserted
  assign wr_flag         = is_dma ? dlat_we : bus.cpu_we;
  assign bus.mem_address = is_dma ? dlat_addr : bus.cpu_address;
  assign bus.mem_wdata   = is_dma ? dlat_wdata : bus.cpu_out;
  assign bus.mem_we      = !reset && slot_end && wr_flag;

  // Core side: runs only on its own slot ends, sees held read data while stalled by DMA
  assign bus.cpu_hold  = reset ? (WAIT == 0) : (!is_dma && slot_end);
  assign bus.cpu_in    = is_dma ? cpu_in_q : bus.mem_rdata;

  assign bus.dma_ack   = !reset && is_dma && slot_end;
  assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four parameterisations driven from vector tables and loops.
// Memory is modelled as a combinational function of the address.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA7 : (a[7:0] ^ 8'h3C);
  endfunction

  mem_arbiter_if #(.ADDR_W(16)) ifa ();
  mem_arbiter_if #(.ADDR_W(16)) ifb ();
  mem_arbiter_if #(.ADDR_W(16)) ifc ();
  mem_arbiter_if #(.ADDR_W(16)) ifd ();

  assign ifa.mem_rdata = memf(ifa.mem_address);
  assign ifb.mem_rdata = memf(ifb.mem_address);
  assign ifc.mem_rdata = memf(ifc.mem_address);
  assign ifd.mem_rdata = memf(ifd.mem_address);

  mem_arbiter #(.ADDR_W(16), .WAIT(1), .CPU_SLOTS(1)) dut_a (.clock(clk), .reset(rst_a), .bus(ifa.slave));
  mem_arbiter #(.ADDR_W(16), .WAIT(0), .CPU_SLOTS(1)) dut_b (.clock(clk), .reset(rst_b), .bus(ifb.slave));
  mem_arbiter #(.ADDR_W(16), .WAIT(0), .CPU_SLOTS(3)) dut_c (.clock(clk), .reset(rst_c), .bus(ifc.slave));
  mem_arbiter #(.ADDR_W(16), .WAIT(2), .CPU_SLOTS(1)) dut_d (.clock(clk), .reset(rst_d), .bus(ifd.slave));

  typedef struct {
    logic        rst;
    logic        req;
    logic        dwe;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic        cwe;
    logic [15:0] caddr;
    logic [7:0]  cout;
    logic        e_hold;
    logic        e_we;
    logic        e_ack;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [7:0]  e_rdata;
    logic [7:0]  e_in;
    logic        ci;
  } vec_t;

  vec_t ta [11];
  vec_t td [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // WAIT=1, CPU_SLOTS=1: CPU writes, then a DMA read of 1234 with the request address changed after grant
    ta[0]  = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0200,8'h5A, 1'b0,1'b0,1'b0,16'h0200,8'h00,8'h00,8'h3C,1'b1};
    ta[1]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0200,8'h5A, 1'b0,1'b0,1'b0,16'h0200,8'h00,8'h00,8'h3C,1'b1};
    ta[2]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0200,8'h5A, 1'b1,1'b1,1'b0,16'h0200,8'h5A,8'h00,8'h3C,1'b1};
    ta[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0200,8'h5A, 1'b0,1'b0,1'b0,16'h0200,8'h00,8'h00,8'h3C,1'b1};
    ta[4]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,16'h0200,8'h5A, 1'b1,1'b1,1'b0,16'h0200,8'h5A,8'h00,8'h3C,1'b1};
    ta[5]  = '{1'b0,1'b1,1'b0,16'h1234,8'h00,1'b0,16'h0355,8'h00, 1'b0,1'b0,1'b0,16'h0355,8'h00,8'h00,8'h69,1'b1};
    ta[6]  = '{1'b0,1'b1,1'b0,16'h1234,8'h00,1'b0,16'h0355,8'h00, 1'b1,1'b0,1'b0,16'h0355,8'h00,8'h00,8'h69,1'b1};
    ta[7]  = '{1'b0,1'b0,1'b1,16'hBEEF,8'h11,1'b0,16'h0355,8'h00, 1'b0,1'b0,1'b0,16'h1234,8'h00,8'h00,8'h69,1'b1};
    ta[8]  = '{1'b0,1'b0,1'b1,16'hBEEF,8'h11,1'b0,16'h0355,8'h00, 1'b0,1'b0,1'b1,16'h1234,8'h00,8'hA7,8'h69,1'b1};
    ta[9]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0355,8'h00, 1'b0,1'b0,1'b0,16'h0355,8'h00,8'h00,8'h69,1'b1};
    ta[10] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0355,8'h00, 1'b1,1'b0,1'b0,16'h0355,8'h00,8'h00,8'h69,1'b1};

    // WAIT=2, CPU_SLOTS=1: short pulse ignored, req dropped after grant, reset inside a DMA write slot
    td[0]  = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[1]  = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[2]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[4]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[5]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[6]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[7]  = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[8]  = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[9]  = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[10] = '{1'b0,1'b0,1'b0,16'hFFFF,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h5678,8'h00,8'h00,8'h00,1'b0};
    td[11] = '{1'b0,1'b0,1'b0,16'hFFFF,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h5678,8'h00,8'h00,8'h00,1'b0};
    td[12] = '{1'b0,1'b0,1'b0,16'hFFFF,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b1,1'b1,16'h5678,8'h9C,8'h44,8'h00,1'b0};
    td[13] = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[14] = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[15] = '{1'b0,1'b1,1'b1,16'h5678,8'h9C,1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[16] = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h5678,8'h00,8'h00,8'h00,1'b0};
    td[17] = '{1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[18] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[19] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b0,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
    td[20] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,16'h0010,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h00,8'h00,8'h00,1'b0};
  end

  initial begin
    logic [15:0] baddr [4];
    baddr[0] = 16'h0001; baddr[1] = 16'hA5C3; baddr[2] = 16'hFFFF; baddr[3] = 16'h7E00;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    ifa.cpu_address = '0; ifa.cpu_out = '0; ifa.cpu_we = 1'b0;
    ifa.dma_req = 1'b0; ifa.dma_address = '0; ifa.dma_wdata = '0; ifa.dma_we = 1'b0;
    ifb.cpu_address = '0; ifb.cpu_out = '0; ifb.cpu_we = 1'b0;
    ifb.dma_req = 1'b0; ifb.dma_address = '0; ifb.dma_wdata = '0; ifb.dma_we = 1'b0;
    ifc.cpu_address = '0; ifc.cpu_out = '0; ifc.cpu_we = 1'b0;
    ifc.dma_req = 1'b0; ifc.dma_address = '0; ifc.dma_wdata = '0; ifc.dma_we = 1'b0;
    ifd.cpu_address = '0; ifd.cpu_out = '0; ifd.cpu_we = 1'b0;
    ifd.dma_req = 1'b0; ifd.dma_address = '0; ifd.dma_wdata = '0; ifd.dma_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      rst_a = ta[i].rst;
      ifa.dma_req = ta[i].req; ifa.dma_we = ta[i].dwe;
      ifa.dma_address = ta[i].daddr; ifa.dma_wdata = ta[i].dwdata;
      ifa.cpu_we = ta[i].cwe; ifa.cpu_address = ta[i].caddr; ifa.cpu_out = ta[i].cout;
      @(negedge clk);
      chk($sformatf("A[%0d] cpu_hold", i), 32'(ifa.cpu_hold), 32'(ta[i].e_hold));
      chk($sformatf("A[%0d] mem_we", i), 32'(ifa.mem_we), 32'(ta[i].e_we));
      chk($sformatf("A[%0d] dma_ack", i), 32'(ifa.dma_ack), 32'(ta[i].e_ack));
      chk($sformatf("A[%0d] mem_address", i), 32'(ifa.mem_address), 32'(ta[i].e_addr));
      if (ta[i].e_we) chk($sformatf("A[%0d] mem_wdata", i), 32'(ifa.mem_wdata), 32'(ta[i].e_wdata));
      if (ta[i].e_ack) chk($sformatf("A[%0d] dma_rdata", i), 32'(ifa.dma_rdata), 32'(ta[i].e_rdata));
      if (ta[i].ci) chk($sformatf("A[%0d] cpu_in", i), 32'(ifa.cpu_in), 32'(ta[i].e_in));
      @(posedge clk);
      #1;
    end
    rst_a = 1'b1;

    // WAIT=0: core never stalls and the address path is transparent
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifb.cpu_address = baddr[k];
      ifb.cpu_we = k[0];
      ifb.cpu_out = 8'(k + 8'h40);
      @(negedge clk);
      chk($sformatf("B[%0d] cpu_hold", k), 32'(ifb.cpu_hold), 32'd1);
      chk($sformatf("B[%0d] mem_address", k), 32'(ifb.mem_address), 32'(baddr[k]));
      chk($sformatf("B[%0d] mem_we", k), 32'(ifb.mem_we), 32'(k[0]));
      chk($sformatf("B[%0d] dma_ack", k), 32'(ifb.dma_ack), 32'd0);
      @(posedge clk);
      #1;
    end
    rst_b = 1'b1;
    ifb.cpu_we = 1'b1;
    @(negedge clk);
    chk("B rst mem_we", 32'(ifb.mem_we), 32'd0);
    chk("B rst cpu_hold", 32'(ifb.cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("B rel cpu_hold", 32'(ifb.cpu_hold), 32'd1);
    chk("B rel mem_we", 32'(ifb.mem_we), 32'd1);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    // WAIT=0, CPU_SLOTS=3, continuous DMA writes: CPU,CPU,CPU,DMA repeating
    rst_c = 1'b0;
    ifc.cpu_address = 16'h0100; ifc.cpu_out = 8'hEE; ifc.cpu_we = 1'b0;
    ifc.dma_req = 1'b1; ifc.dma_we = 1'b1; ifc.dma_address = 16'h4ABC;
    for (int k = 0; k < 8; k++) begin
      ifc.dma_wdata = 8'(8'h10 + k);
      @(negedge clk);
      if ((k % 4) == 3) begin
        chk($sformatf("C[%0d] cpu_hold", k), 32'(ifc.cpu_hold), 32'd0);
        chk($sformatf("C[%0d] dma_ack", k), 32'(ifc.dma_ack), 32'd1);
        chk($sformatf("C[%0d] mem_we", k), 32'(ifc.mem_we), 32'd1);
        chk($sformatf("C[%0d] mem_address", k), 32'(ifc.mem_address), 32'h4ABC);
        chk($sformatf("C[%0d] mem_wdata", k), 32'(ifc.mem_wdata), 32'(8'h10 + k - 1));
        chk($sformatf("C[%0d] dma_rdata", k), 32'(ifc.dma_rdata), 32'h80);
      end else begin
        chk($sformatf("C[%0d] cpu_hold", k), 32'(ifc.cpu_hold), 32'd1);
        chk($sformatf("C[%0d] dma_ack", k), 32'(ifc.dma_ack), 32'd0);
        chk($sformatf("C[%0d] mem_we", k), 32'(ifc.mem_we), 32'd0);
        chk($sformatf("C[%0d] mem_address", k), 32'(ifc.mem_address), 32'h0100);
      end
      @(posedge clk);
      #1;
    end
    rst_c = 1'b1;

    for (int i = 0; i < 21; i++) begin
      rst_d = td[i].rst;
      ifd.dma_req = td[i].req; ifd.dma_we = td[i].dwe;
      ifd.dma_address = td[i].daddr; ifd.dma_wdata = td[i].dwdata;
      ifd.cpu_we = td[i].cwe; ifd.cpu_address = td[i].caddr; ifd.cpu_out = td[i].cout;
      @(negedge clk);
      chk($sformatf("D[%0d] cpu_hold", i), 32'(ifd.cpu_hold), 32'(td[i].e_hold));
      chk($sformatf("D[%0d] mem_we", i), 32'(ifd.mem_we), 32'(td[i].e_we));
      chk($sformatf("D[%0d] dma_ack", i), 32'(ifd.dma_ack), 32'(td[i].e_ack));
      chk($sformatf("D[%0d] mem_address", i), 32'(ifd.mem_address), 32'(td[i].e_addr));
      if (td[i].e_we) chk($sformatf("D[%0d] mem_wdata", i), 32'(ifd.mem_wdata), 32'(td[i].e_wdata));
      if (td[i].e_ack) chk($sformatf("D[%0d] dma_rdata", i), 32'(ifd.dma_rdata), 32'(td[i].e_rdata));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
